// File: rtl/split_checker.sv
`timescale 1ns/1ps
// Purpose : checks a captured operand pair (A, B) against four constraints,
//           one constraint per cycle, and reports pass or the first failing index.
// Latency : k+1 cycles from accept to out_valid when constraint k fails, 4 on pass.
// Backpr. : in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b sampled on accept
//   out_valid/out_ready   result handshake; out_x = all enabled constraints hold,
//                         out_fail_idx = first failing constraint (0 on pass)
//   stat_clr              synchronous clear of the statistics counters
//   pass_cnt, fail_cnt    saturating result counters
//
// Optional feature: define SPLIT_CHECKER_STATS_EN to build the statistics
// counters. Without it the counter ports read constant 0 and stat_clr is ignored.
module split_checker #(
  parameter int            W     = 16,
  parameter int            SHIFT = 6,
  parameter logic [W-1:0]  MASK  = W'(16'h8622),
  parameter logic [3:0]    CEN   = 4'hF,
  parameter int            CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_x,
  output logic [1:0]    out_fail_idx,
  input  logic          stat_clr,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   k;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  // Constraint evaluation on the captured operands only, so the live inputs
  // can change freely once a transaction has been accepted.
  logic         b_zero;
  logic [W-1:0] b_shl;
  logic [3:0]   c_hold;
  logic [3:0]   c_ok;
  logic         k_ok;

  assign b_zero    = (b_q == '0);
  assign b_shl     = b_q << SHIFT;
  assign c_hold[0] = (a_q == '0);
  assign c_hold[1] = b_zero;
  assign c_hold[2] = ({{(W-1){1'b0}}, b_zero} != a_q);
  assign c_hold[3] = ((b_shl | MASK) != '0);

  // A disabled constraint is forced to pass but still costs its EVAL cycle.
  assign c_ok = c_hold | ~CEN;
  assign k_ok = c_ok[k];

  // Control FSM with registered handshake and result outputs.
  // in_ready is a flop so that it stays low during reset and rises on the
  // first edge after release; it is also low in the cycle a result is
  // consumed, so no accept can coincide with the DONE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_x        <= 1'b0;
      out_fail_idx <= 2'd0;
      k            <= 2'd0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            k        <= 2'd0;
            in_ready <= 1'b0;
            state    <= EVAL;
          end else begin
            in_ready <= 1'b1;
          end
        end
        EVAL: begin
          if (!k_ok) begin
            out_valid    <= 1'b1;
            out_x        <= 1'b0;
            out_fail_idx <= k;
            state        <= DONE;
          end else if (k == 2'd3) begin
            out_valid    <= 1'b1;
            out_x        <= 1'b1;
            out_fail_idx <= 2'd0;
            state        <= DONE;
          end else begin
            k <= k + 2'd1;
          end
        end
        DONE: begin
          // out_x / out_fail_idx are left untouched here, so they stay
          // stable for as long as the consumer stalls.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef SPLIT_CHECKER_STATS_EN
  // Counters update on the cycle the result is consumed; a reset while a
  // transaction is in flight never reaches this point, so it is not counted.
  logic done_hs;
  assign done_hs = (state == DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (stat_clr) begin
      // Clear has priority over a coincident increment.
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (done_hs) begin
      if (out_x) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CW'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = stat_clr;
  assign pass_cnt     = '0;
  assign fail_cnt     = '0;
`endif

endmodule

// File: doc/split_checker.md
SPLIT_CHECKER -- requirements
Module: split_checker

Interface
REQ-001 The module SHALL have parameter W, default 16, operand width in bits (W >= 2).
REQ-002 The module SHALL have parameter SHIFT, default 6, left-shift amount for constraint 3 (0 <= SHIFT < W).
REQ-003 The module SHALL have parameter MASK, default 16'h8622 truncated or zero-extended to W bits, OR-constant for constraint 3.
REQ-004 The module SHALL have parameter CEN, default 4'hF; bit k enables constraint k, and a disabled constraint counts as pass.
REQ-005 The module SHALL have parameter CW, default 16, statistics counter width.
REQ-006 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port in_valid, input, 1, transaction offered.
REQ-009 The module SHALL have port in_ready, output, 1, transaction accepted when high together with in_valid.
REQ-010 The module SHALL have ports in_a and in_b, input, W each, operands.
REQ-011 The module SHALL have port out_valid, output, 1, result available.
REQ-012 The module SHALL have port out_ready, input, 1, result consumed when high together with out_valid.
REQ-013 The module SHALL have port out_x, output, 1, set to 1 when all enabled constraints hold.
REQ-014 The module SHALL have port out_fail_idx, output, 2, index of the first failing constraint, and 0 when out_x is 1.
REQ-015 The module SHALL have ports stat_clr (input, 1), pass_cnt (output, CW) and fail_cnt (output, CW).

Function
REQ-016 The constraints SHALL be evaluated on the captured operands A and B as: c0 = (A == 0); c1 = (B == 0); c2 = (zero-extended (B == 0)) != A; c3 = (((B << SHIFT) truncated to W) | MASK) != 0.
REQ-017 The FSM SHALL have three states, IDLE, EVAL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, when in_valid is 1, the block SHALL capture in_a and in_b into internal registers, set index k to 0 and go to EVAL.
REQ-019 In EVAL, each cycle SHALL test constraint k only; a disabled constraint still takes one cycle.
REQ-020 In EVAL, a failing enabled constraint SHALL end evaluation early: go to DONE with out_x = 0 and out_fail_idx = k.
REQ-021 In EVAL, when k = 3 passes, the block SHALL go to DONE with out_x = 1 and out_fail_idx = 0; otherwise k SHALL increment.
REQ-022 Latency from the accept edge to out_valid SHALL be k+1 cycles when constraint k fails, and 4 cycles on a pass.
REQ-023 out_valid SHALL be 1 only in DONE, and out_x and out_fail_idx SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-024 In DONE, when out_ready is 1, the block SHALL return to IDLE, with no new accept in that same cycle; throughput is at most one transaction per 2+latency cycles.
REQ-025 Changes on in_a and in_b after the accept edge SHALL have no effect on the transaction in flight.

Reset
REQ-026 When rst_n is low, the block SHALL immediately go to IDLE and clear in_ready, out_valid, out_x, out_fail_idx, k, the operand registers, pass_cnt and fail_cnt; in_ready SHALL go to 1 on the first clock edge after rst_n goes high.
REQ-027 Reset asserted during EVAL or DONE SHALL discard the in-flight transaction, and no counter SHALL update for it.

Configuration
REQ-028 When macro SPLIT_CHECKER_STATS_EN is defined, pass_cnt or fail_cnt SHALL increment on the DONE handshake cycle according to out_x, saturating at all-ones.
REQ-029 With SPLIT_CHECKER_STATS_EN defined, stat_clr = 1 SHALL synchronously zero both counters, and a clear SHALL win over a simultaneous increment.
REQ-030 Without SPLIT_CHECKER_STATS_EN, the ports SHALL remain present, pass_cnt and fail_cnt SHALL be constant 0, stat_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-031 The bench SHALL cover: defaults, A=0, B=0 -> out_valid 4 cycles after accept, out_x=1, out_fail_idx=0, pass_cnt=1 (stats on).
REQ-032 The bench SHALL cover: defaults, A=16'h0005, B=0 -> out_valid 1 cycle after accept, out_x=0, out_fail_idx=0, fail_cnt=1.
REQ-033 The bench SHALL cover: CEN=4'b1100, A=16'h0001, B=0 -> c2 fails, out_valid 3 cycles after accept, out_fail_idx=2.
REQ-034 The bench SHALL cover: CEN=4'b1000, MASK=0, B=16'h0400 -> shifted value wraps to 0, out_x=0, out_fail_idx=3, latency 4.
REQ-035 The bench SHALL cover: out_ready held low 10 cycles -> out_valid, out_x and out_fail_idx stable, in_ready=0, and a new in_valid is not accepted.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-EVAL -> outputs 0 without a clock edge, counters 0; and stat_clr coincident with a pass handshake -> pass_cnt=0.
